mbank_axil_frontend: RTL and testbench
======================================

# mbank_axil_frontend

AXI4-Lite slave front end for the mbank simple dual-port RAM. It accepts write transactions and drives them into RAM port A (`wea`/`addra`/`dina`), and it accepts read transactions, drives RAM port B (`addrb`) and returns `doutb` on the R channel. It sits directly upstream of `simple_dual_port_ram`, and its RAM-side ports connect 1:1 to it.

## Interface
Parameters:
- `DATA_W`, 32: data width, and the RAM word width.
- `ADDR_W`, 8: RAM word-address width (depth = 2**`ADDR_W`).
- `AXI_ADDR_W`, 12: AXI byte-address width; must be ≥ `ADDR_W`+2.
- `RD_LAT`, 1: RAM port-B read latency in clocks (registered read); legal range 1–4.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: synchronous, active-high reset.
- `s_awaddr` in `AXI_ADDR_W`, `s_awvalid` in 1, `s_awready` out 1: write address channel.
- `s_wdata` in `DATA_W`, `s_wvalid` in 1, `s_wready` out 1: write data channel. No WSTRB; all writes are full-word.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write response channel.
- `s_araddr` in `AXI_ADDR_W`, `s_arvalid` in 1, `s_arready` out 1: read address channel.
- `s_rdata` out `DATA_W`, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: read data channel.
- `wea` out 1, `addra` out `ADDR_W`, `dina` out `DATA_W`: RAM port A (write).
- `addrb` out `ADDR_W`, `doutb` in `DATA_W`: RAM port B (read).

## Operation
- Word index = `addr[ADDR_W+1:2]`. Bits [1:0] are ignored.
- Write FSM states:
  - W_IDLE: `s_awready`=1 until AW is captured; `s_wready`=1 until W is captured. AW and W are latched independently, in either order or in the same cycle. Once both are held, go to W_WRITE.
  - W_WRITE: exactly one cycle with `wea`=1, `addra`=latched index, `dina`=latched data. Then go to W_RESP.
  - W_RESP: `s_bvalid`=1 with `s_bresp` stable until `s_bready`. Then return to W_IDLE.
- Read FSM states:
  - R_IDLE: `s_arready`=1, except 0 while the write FSM is in W_WRITE. This orders a read behind a same-cycle write, so the read returns the new data. An AR handshake latches the index and goes to R_WAIT.
  - R_WAIT: `addrb` held; an `RD_LAT`-cycle counter runs. When it expires, `doutb` is captured into `s_rdata` and the FSM goes to R_RESP.
  - R_RESP: `s_rvalid`=1 with `s_rdata`/`s_rresp` stable until `s_rready`. Then return to R_IDLE.
- Read and write FSMs run concurrently; one outstanding transaction per direction.
- `addrb` holds its last value when idle; `wea` is 0 outside W_WRITE.

## Timing
- Reset values: `s_awready`=0, `s_wready`=0, `s_arready`=0, `s_bvalid`=0, `s_rvalid`=0, `s_bresp`=0, `s_rresp`=0, `s_rdata`=0, `wea`=0, `addra`=0, `dina`=0, `addrb`=0. Ready outputs rise on the first cycle after `rst` deasserts.
- Write: AW and W both complete by edge N → `wea`=1 in cycle N+1 → `s_bvalid`=1 from cycle N+2.
- Read: AR handshake at edge N → `addrb` valid in cycle N+1 → `s_rvalid`=1 from cycle N+1+`RD_LAT`.
- Back-to-back: a new AW/W (or AR) is accepted in the cycle after the B (or R) handshake.
- `rst` mid-transaction: both FSMs return to idle, pending B/R responses are dropped, and `wea` is forced to 0 in the same cycle.
- Address 0x...FFC (max index) followed by index 0: no wrap state is involved; each is an independent access.

## Configuration
- `MBANK_ADDR_CHECK_EN` defined:
  - Any set bit in `addr[AXI_ADDR_W-1:ADDR_W+2]` makes the access out of range.
  - Out-of-range write: `wea` is suppressed (W_WRITE still takes its one cycle) and `s_bresp`=2'b10 (SLVERR).
  - Out-of-range read: `s_rdata`=0 and `s_rresp`=2'b10. Timing is unchanged.
- `MBANK_ADDR_CHECK_EN` undefined: upper bits are ignored (address aliases), and responses are always 2'b00 (OKAY).

## Test plan
- Reset then idle: all outputs equal their reset values during `rst`, and ready outputs are 1 one cycle after release.
- W before AW: W 0xA5A5_0001 at cycle 3, AW 0x010 at cycle 6 → `wea`=1 with `addra`=4, `dina`=0xA5A5_0001 in cycle 7; `s_bvalid`=1 in cycle 8 with `s_bresp`=0.
- Write then read of index 4 with `RD_LAT`=1 → `s_rvalid` 2 cycles after AR, `s_rdata`=0xA5A5_0001. With `s_rready` held low for 3 cycles, `s_rdata` stays stable.
- AR issued in the cycle the write FSM is in W_WRITE to the same index → `s_arready`=0 that cycle, and the read returns the newly written data.
- With `MBANK_ADDR_CHECK_EN`: write to 0x400 → no `wea` pulse, `s_bresp`=2'b10. Without the macro: the same write lands at index 0 with OKAY.
- `rst` asserted during R_WAIT → `s_rvalid` never rises, and a following AR completes normally.

Source files
------------

// File: rtl/mbank_axil_frontend.sv
// AXI4-Lite slave front end for the mbank simple dual-port RAM (port A write, port B read).
// Optional macro MBANK_ADDR_CHECK_EN: flags accesses with upper address bits set as SLVERR.
module mbank_axil_frontend #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned AXI_ADDR_W = 12,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AXI_ADDR_W-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [AXI_ADDR_W-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic                  wea,
   output logic [ADDR_W-1:0]     addra,
   output logic [DATA_W-1:0]     dina,
   output logic [ADDR_W-1:0]     addrb,
   input  logic [DATA_W-1:0]     doutb
);

   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

   w_state_t             w_state;
   r_state_t             r_state;
   logic                 aw_held, w_held, aw_oor_q, wea_q;
   logic [ADDR_W-1:0]    aw_idx_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [CNT_W-1:0]     rd_cnt;
   logic                 rd_oor, rd_first;
   logic [DATA_W-1:0]    rdata_q;

   logic                 aw_hs_c, w_hs_c, ar_hs_c, aw_got_c, w_got_c, w_enter_c;
   logic                 aw_oor_c, ar_oor_c, wr_oor_c;
   logic [ADDR_W-1:0]    aw_idx_c, ar_idx_c, wr_idx_c;
   logic [DATA_W-1:0]    wr_data_c, rd_word_c;

   assign aw_idx_c = s_awaddr[ADDR_W+1:2];
   assign ar_idx_c = s_araddr[ADDR_W+1:2];

`ifdef MBANK_ADDR_CHECK_EN
   assign aw_oor_c = (s_awaddr >> (ADDR_W + 2)) != '0;
   assign ar_oor_c = (s_araddr >> (ADDR_W + 2)) != '0;
   wire unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};
`else
   // Upper address bits alias onto the RAM; no error responses are generated.
   assign aw_oor_c = 1'b0;
   assign ar_oor_c = 1'b0;
   wire unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0],
                             s_awaddr[AXI_ADDR_W-1:ADDR_W+2], s_araddr[AXI_ADDR_W-1:ADDR_W+2]};
`endif

   assign aw_hs_c   = s_awready & s_awvalid;
   assign w_hs_c    = s_wready & s_wvalid;
   assign ar_hs_c   = s_arready & s_arvalid;
   assign aw_got_c  = aw_held | aw_hs_c;
   assign w_got_c   = w_held | w_hs_c;
   assign w_enter_c = (w_state == W_IDLE) && aw_got_c && w_got_c;
   assign wr_idx_c  = aw_hs_c ? aw_idx_c : aw_idx_q;
   assign wr_oor_c  = aw_hs_c ? aw_oor_c : aw_oor_q;
   assign wr_data_c = w_hs_c ? s_wdata : wdata_q;

   // Reset kills a write strobe in the very cycle it is raised.
   assign wea = wea_q & ~rst;

   // Write channel: AW and W captured independently, one RAM strobe, then B.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state   <= W_IDLE;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bresp   <= 2'b00;
         wea_q     <= 1'b0;
         addra     <= '0;
         dina      <= '0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_idx_q  <= '0;
         aw_oor_q  <= 1'b0;
         wdata_q   <= '0;
      end else begin
         wea_q <= 1'b0;
         case (w_state)
            W_IDLE: begin
               if (aw_hs_c) begin
                  aw_held  <= 1'b1;
                  aw_idx_q <= aw_idx_c;
                  aw_oor_q <= aw_oor_c;
               end
               if (w_hs_c) begin
                  w_held  <= 1'b1;
                  wdata_q <= s_wdata;
               end
               if (w_enter_c) begin
                  w_state   <= W_WRITE;
                  s_awready <= 1'b0;
                  s_wready  <= 1'b0;
                  aw_held   <= 1'b0;
                  w_held    <= 1'b0;
                  wea_q     <= ~wr_oor_c;
                  addra     <= wr_idx_c;
                  dina      <= wr_data_c;
                  s_bresp   <= wr_oor_c ? 2'b10 : 2'b00;
               end else begin
                  s_awready <= ~aw_got_c;
                  s_wready  <= ~w_got_c;
               end
            end
            W_WRITE: begin
               w_state  <= W_RESP;
               s_bvalid <= 1'b1;
            end
            W_RESP: begin
               if (s_bready) begin
                  w_state   <= W_IDLE;
                  s_bvalid  <= 1'b0;
                  s_awready <= 1'b1;
                  s_wready  <= 1'b1;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // First R_RESP cycle forwards the RAM output directly; later cycles replay the held copy.
   assign rd_word_c = rd_oor ? '0 : doutb;
   assign s_rdata   = rd_first ? rd_word_c : rdata_q;

   // Read channel: AR is held off while a RAM write is in flight so reads see it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= R_IDLE;
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rresp   <= 2'b00;
         addrb     <= '0;
         rd_cnt    <= '0;
         rd_oor    <= 1'b0;
         rd_first  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs_c) begin
                  r_state   <= R_WAIT;
                  s_arready <= 1'b0;
                  addrb     <= ar_idx_c;
                  rd_oor    <= ar_oor_c;
                  rd_cnt    <= CNT_W'(RD_LAT - 1);
               end else begin
                  s_arready <= ~w_enter_c;
               end
            end
            R_WAIT: begin
               if (rd_cnt == '0) begin
                  r_state  <= R_RESP;
                  s_rvalid <= 1'b1;
                  rd_first <= 1'b1;
                  s_rresp  <= rd_oor ? 2'b10 : 2'b00;
               end else begin
                  rd_cnt <= rd_cnt - CNT_W'(1);
               end
            end
            R_RESP: begin
               rd_first <= 1'b0;
               if (rd_first) rdata_q <= rd_word_c;
               if (s_rready) begin
                  r_state   <= R_IDLE;
                  s_rvalid  <= 1'b0;
                  s_arready <= ~w_enter_c;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mbank_axil_frontend.sv
// Directed bench for mbank_axil_frontend with a behavioural 1-cycle-latency RAM model attached.
module tb_mbank_axil_frontend;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] s_awaddr, s_araddr;
   logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
   logic [31:0] s_wdata;
   logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;
   logic        wea;
   logic [7:0]  addra, addrb;
   logic [31:0] dina, doutb;

   int checks = 0;
   int errors = 0;

   logic        mem_clr;
   logic [31:0] mem [256];

   always #5 clk = ~clk;

   mbank_axil_frontend dut (
      .clk(clk), .rst(rst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .wea(wea), .addra(addra), .dina(dina),
      .addrb(addrb), .doutb(doutb)
   );

   // Simple dual-port RAM, registered read of one cycle.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      end else if (wea) begin
         mem[addra] <= dina;
      end
      doutb <= mem[addrb];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [7:0] idx,
                           input logic ewea, input logic [1:0] eresp);
      chk("wr_awready", 32'(s_awready), 32'd1);
      chk("wr_wready", 32'(s_wready), 32'd1);
      s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      chk("wr_wea", 32'(wea), 32'(ewea));
      chk("wr_addra", 32'(addra), 32'(idx));
      chk("wr_dina", dina, d);
      step();
      chk("wr_bvalid", 32'(s_bvalid), 32'd1);
      chk("wr_bresp", 32'(s_bresp), 32'(eresp));
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      chk("wr_bdone", 32'(s_bvalid), 32'd0);
   endtask

   task automatic do_read(input logic [11:0] a, input logic [7:0] idx,
                          input logic [31:0] ed, input logic [1:0] eresp);
      chk("rd_arready", 32'(s_arready), 32'd1);
      s_araddr = a; s_arvalid = 1'b1;
      step();
      s_arvalid = 1'b0;
      chk("rd_addrb", 32'(addrb), 32'(idx));
      chk("rd_rvalid_early", 32'(s_rvalid), 32'd0);
      step();
      chk("rd_rvalid", 32'(s_rvalid), 32'd1);
      chk("rd_rdata", s_rdata, ed);
      chk("rd_rresp", 32'(s_rresp), 32'(eresp));
      s_rready = 1'b1;
      step();
      s_rready = 1'b0;
      chk("rd_rdone", 32'(s_rvalid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; mem_clr = 1'b1;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

      // Reset values
      step(); step(); step();
      chk("rst_awready", 32'(s_awready), 32'd0);
      chk("rst_wready", 32'(s_wready), 32'd0);
      chk("rst_arready", 32'(s_arready), 32'd0);
      chk("rst_bvalid", 32'(s_bvalid), 32'd0);
      chk("rst_rvalid", 32'(s_rvalid), 32'd0);
      chk("rst_bresp", 32'(s_bresp), 32'd0);
      chk("rst_rresp", 32'(s_rresp), 32'd0);
      chk("rst_rdata", s_rdata, 32'd0);
      chk("rst_wea", 32'(wea), 32'd0);
      chk("rst_addra", 32'(addra), 32'd0);
      chk("rst_dina", dina, 32'd0);
      chk("rst_addrb", 32'(addrb), 32'd0);
      rst = 1'b0; mem_clr = 1'b0;
      chk("rel_awready", 32'(s_awready), 32'd0);
      step();
      chk("idle_awready", 32'(s_awready), 32'd1);
      chk("idle_wready", 32'(s_wready), 32'd1);
      chk("idle_arready", 32'(s_arready), 32'd1);

      // W three cycles ahead of AW
      s_wdata = 32'hA5A5_0001; s_wvalid = 1'b1;
      step();
      s_wvalid = 1'b0;
      chk("wfirst_wready", 32'(s_wready), 32'd0);
      chk("wfirst_awready", 32'(s_awready), 32'd1);
      chk("wfirst_wea_a", 32'(wea), 32'd0);
      step();
      chk("wfirst_wea_b", 32'(wea), 32'd0);
      step();
      s_awaddr = 12'h010; s_awvalid = 1'b1;
      step();
      s_awvalid = 1'b0;
      chk("wfirst_wea", 32'(wea), 32'd1);
      chk("wfirst_addra", 32'(addra), 32'd4);
      chk("wfirst_dina", dina, 32'hA5A5_0001);
      chk("wfirst_arready_blk", 32'(s_arready), 32'd0);
      step();
      chk("wfirst_wea_off", 32'(wea), 32'd0);
      chk("wfirst_bvalid", 32'(s_bvalid), 32'd1);
      chk("wfirst_bresp", 32'(s_bresp), 32'd0);
      step();
      chk("wfirst_bhold", 32'(s_bvalid), 32'd1);
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      chk("wfirst_bdone", 32'(s_bvalid), 32'd0);
      chk("b2b_awready", 32'(s_awready), 32'd1);
      chk("b2b_wready", 32'(s_wready), 32'd1);

      // Read index 4 with R stalled while index 4 is rewritten underneath
      s_araddr = 12'h010; s_arvalid = 1'b1;
      step();
      s_arvalid = 1'b0;
      chk("stall_addrb", 32'(addrb), 32'd4);
      chk("stall_rvalid0", 32'(s_rvalid), 32'd0);
      step();
      chk("stall_rvalid", 32'(s_rvalid), 32'd1);
      chk("stall_rdata0", s_rdata, 32'hA5A5_0001);
      s_awaddr = 12'h010; s_awvalid = 1'b1; s_wdata = 32'h1234_5678; s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      chk("stall_wea", 32'(wea), 32'd1);
      chk("stall_rdata1", s_rdata, 32'hA5A5_0001);
      step();
      chk("stall_rdata2", s_rdata, 32'hA5A5_0001);
      chk("stall_bvalid", 32'(s_bvalid), 32'd1);
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      chk("stall_rdata3", s_rdata, 32'hA5A5_0001);
      chk("stall_rhold", 32'(s_rvalid), 32'd1);
      s_rready = 1'b1;
      step();
      s_rready = 1'b0;
      chk("stall_rdone", 32'(s_rvalid), 32'd0);
      do_read(12'h010, 8'd4, 32'h1234_5678, 2'b00);

      // AR presented while the write strobe is active: must wait and see new data
      s_awaddr = 12'h020; s_awvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      s_araddr = 12'h020; s_arvalid = 1'b1;
      chk("ord_wea", 32'(wea), 32'd1);
      chk("ord_arready_blk", 32'(s_arready), 32'd0);
      step();
      chk("ord_arready", 32'(s_arready), 32'd1);
      chk("ord_bvalid", 32'(s_bvalid), 32'd1);
      s_bready = 1'b1;
      step();
      s_arvalid = 1'b0; s_bready = 1'b0;
      chk("ord_addrb", 32'(addrb), 32'd8);
      step();
      chk("ord_rvalid", 32'(s_rvalid), 32'd1);
      chk("ord_rdata", s_rdata, 32'hDEAD_BEEF);
      s_rready = 1'b1;
      step();
      s_rready = 1'b0;
      chk("ord_rdone", 32'(s_rvalid), 32'd0);

      // Max index then index 0, then an address above the RAM
      do_write(12'h3FC, 32'h0000_00FF, 8'd255, 1'b1, 2'b00);
      do_write(12'h000, 32'h0000_0011, 8'd0, 1'b1, 2'b00);
`ifdef MBANK_ADDR_CHECK_EN
      do_write(12'h400, 32'h0000_0077, 8'd0, 1'b0, 2'b10);
      do_read(12'h3FC, 8'd255, 32'h0000_00FF, 2'b00);
      do_read(12'h000, 8'd0, 32'h0000_0011, 2'b00);
      do_read(12'h400, 8'd0, 32'h0000_0000, 2'b10);
`else
      do_write(12'h400, 32'h0000_0077, 8'd0, 1'b1, 2'b00);
      do_read(12'h3FC, 8'd255, 32'h0000_00FF, 2'b00);
      do_read(12'h000, 8'd0, 32'h0000_0077, 2'b00);
      do_read(12'h400, 8'd0, 32'h0000_0077, 2'b00);
`endif

      // Reset while a read waits on the RAM
      s_araddr = 12'h3FC; s_arvalid = 1'b1;
      step();
      s_arvalid = 1'b0;
      chk("rrst_addrb", 32'(addrb), 32'd255);
      rst = 1'b1;
      step();
      chk("rrst_rvalid0", 32'(s_rvalid), 32'd0);
      chk("rrst_arready", 32'(s_arready), 32'd0);
      rst = 1'b0;
      step();
      chk("rrst_rvalid1", 32'(s_rvalid), 32'd0);
      chk("rrst_arready1", 32'(s_arready), 32'd1);
      step();
      chk("rrst_rvalid2", 32'(s_rvalid), 32'd0);
      do_read(12'h020, 8'd8, 32'hDEAD_BEEF, 2'b00);

      // Reset during the write strobe: strobe dropped immediately, no B
      s_awaddr = 12'h008; s_awvalid = 1'b1; s_wdata = 32'h5555_5555; s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      rst = 1'b1;
      #1;
      chk("wrst_wea", 32'(wea), 32'd0);
      step();
      chk("wrst_bvalid", 32'(s_bvalid), 32'd0);
      chk("wrst_awready", 32'(s_awready), 32'd0);
      rst = 1'b0;
      step();
      chk("wrst_bvalid1", 32'(s_bvalid), 32'd0);
      chk("wrst_awready1", 32'(s_awready), 32'd1);
      do_read(12'h008, 8'd2, 32'h0000_0000, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
